des_engine_arbiter: RTL

//  Shares one des_core among NUM_REQ requesters. Round-robin arbitration.

---
 rtl/des_engine_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/des_engine_arbiter.sv
// rtl/des_engine_arbiter.sv - round-robin arbiter sharing one des_core among NUM_REQ requesters
// Optional watchdog in WAIT enabled by defining DES_ARB_WATCHDOG_EN.
module des_engine_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int REQ_IDX_W      = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_din,
    input  logic [0:64*NUM_REQ-1]    plaintext_din,
    input  logic [0:64*NUM_REQ-1]    key_din,
    output logic [NUM_REQ-1:0]       grant_dout,
    output logic [NUM_REQ-1:0]       done_dout,
    output logic [0:63]              ciphertext_dout,
    output logic                     timeout_strobe_dout,
    output logic                     start_strobe_dout,
    output logic [0:63]              plaintext_dout,
    output logic [0:63]              key_dout,
    input  logic                     active_des_engine_din,
    input  logic                     done_strobe_din,
    input  logic [0:63]              ciphertext_din
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    localparam logic [NUM_REQ-1:0]   ONE_HOT0 = NUM_REQ'(1);
    localparam logic [REQ_IDX_W-1:0] LAST_IDX = REQ_IDX_W'(NUM_REQ - 1);

    if (REQ_IDX_W != $clog2(NUM_REQ)) begin : g_idx_w_check
        $error("REQ_IDX_W must equal clog2(NUM_REQ)");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must fit the 8-bit watchdog counter");
    end

    state_t                 state_q, state_d;
    logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [REQ_IDX_W-1:0]   winner_q, winner_d;
    logic [0:63]            pt_q, pt_d;
    logic [0:63]            key_q, key_d;
    logic [0:63]            ct_q, ct_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   start_q, start_d;

`ifdef DES_ARB_WATCHDOG_EN
    localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]             wd_cnt_q, wd_cnt_d;
    logic                   timeout_q, timeout_d;
`endif

    // Per-requester operand slices as arrays so the winner can be picked by index
    logic [0:63] pt_arr  [NUM_REQ];
    logic [0:63] key_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign pt_arr[g]  = plaintext_din[64*g +: 64];
        assign key_arr[g] = key_din[64*g +: 64];
    end

    logic                   arb_found;
    logic [REQ_IDX_W-1:0]   arb_idx;
    logic [REQ_IDX_W-1:0]   arb_cand;

    // First set request at or after rr_ptr, wrapping at NUM_REQ
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            arb_cand = REQ_IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!arb_found && req_din[arb_cand]) begin
                arb_found = 1'b1;
                arb_idx   = arb_cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        winner_d = winner_q;
        pt_d     = pt_q;
        key_d    = key_q;
        ct_d     = ct_q;
        grant_d  = '0;
        done_d   = '0;
        start_d  = 1'b0;
`ifdef DES_ARB_WATCHDOG_EN
        wd_cnt_d  = wd_cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    winner_d = arb_idx;
                    pt_d     = pt_arr[arb_idx];
                    key_d    = key_arr[arb_idx];
                    grant_d  = ONE_HOT0 << arb_idx;
                    rr_ptr_d = (arb_idx == LAST_IDX) ? '0 : arb_idx + REQ_IDX_W'(1);
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!active_des_engine_din) begin
                    start_d = 1'b1;
                    state_d = S_WAIT;
`ifdef DES_ARB_WATCHDOG_EN
                    wd_cnt_d = '0;
`endif
                end
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle takes priority over the timeout
                if (done_strobe_din) begin
                    ct_d    = ciphertext_din;
                    done_d  = ONE_HOT0 << winner_q;
                    state_d = S_RESPOND;
                end
`ifdef DES_ARB_WATCHDOG_EN
                else if (wd_cnt_q == TMO_LAST) begin
                    ct_d      = '0;
                    done_d    = ONE_HOT0 << winner_q;
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
`endif
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            winner_q <= '0;
            pt_q     <= '0;
            key_q    <= '0;
            ct_q     <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            start_q  <= 1'b0;
`ifdef DES_ARB_WATCHDOG_EN
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            winner_q <= winner_d;
            pt_q     <= pt_d;
            key_q    <= key_d;
            ct_q     <= ct_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            start_q  <= start_d;
`ifdef DES_ARB_WATCHDOG_EN
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign grant_dout        = grant_q;
    assign done_dout         = done_q;
    assign ciphertext_dout   = ct_q;
    assign start_strobe_dout = start_q;
    assign plaintext_dout    = pt_q;
    assign key_dout          = key_q;

`ifdef DES_ARB_WATCHDOG_EN
    assign timeout_strobe_dout = timeout_q;
`else
    assign timeout_strobe_dout = 1'b0;
`endif

endmodule
